// File: rtl/spi_arbiter_pkg.sv
// Shared types and constants for the three-requester SPI arbiter.
// Imported by the arbiter top and its round-robin selector.
package spi_arbiter_pkg;

  localparam int NUM_REQ                = 3;
  localparam int SS_W                   = 3;
  localparam int WORD_W                 = 16;
  localparam int RDATA_W                = 8;
  localparam int TIMEOUT_CYCLES_DEFAULT = 4096;

  localparam logic [RDATA_W-1:0] RESP_TIMEOUT = 8'hEE;
  // Starting "last winner" of 2 gives requester 0 first priority after reset
  localparam logic [1:0]         LAST_RESET   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_BUSY,
    ST_DONE
  } arb_state_e;

  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 12) ? 12 : w;
  endfunction

endpackage

// File: rtl/spi_arbiter_rr_arb3.sv
// Combinational round-robin selector for three requesters.
// Priority order after winner 'last' is last+1, last+2, last (mod 3).
module rr_arb3
  import spi_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [NUM_REQ-1:0] win,
  output logic [1:0]         win_idx
);

  logic [1:0] prio0, prio1, prio2;

  // An out-of-range 'last' falls back to the post-reset order 0, 1, 2
  always_comb begin
    case (last)
      2'd0: begin
        prio0 = 2'd1;
        prio1 = 2'd2;
        prio2 = 2'd0;
      end
      2'd1: begin
        prio0 = 2'd2;
        prio1 = 2'd0;
        prio2 = 2'd1;
      end
      default: begin
        prio0 = 2'd0;
        prio1 = 2'd1;
        prio2 = 2'd2;
      end
    endcase
  end

  always_comb begin
    win_idx = 2'd0;
    if (req[prio0]) begin
      win_idx = prio0;
    end else if (req[prio1]) begin
      win_idx = prio1;
    end else if (req[prio2]) begin
      win_idx = prio2;
    end
    win = (|req) ? (3'b001 << win_idx) : '0;
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master between three requesters with round-robin grant,
// a bounded BUSY wait and a one-cycle completion pulse to the owner.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [SS_W*NUM_REQ-1:0]     req_ss,
  input  logic [WORD_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          done,
  output logic [RDATA_W-1:0]          rsp_data,
  output logic                        timeout_err,
  output logic                        wrt_SPI,
  output logic [WORD_W-1:0]           SPI_data,
  output logic [SS_W-1:0]             ss,
  input  logic                        SPI_done,
  input  logic [RDATA_W-1:0]          SPI_rdata
);

  localparam int                CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e           state_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [RDATA_W-1:0]   rsp_q;
  logic                 terr_q;
  logic                 wrt_q;
  logic [WORD_W-1:0]    data_q;
  logic [SS_W-1:0]      ss_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [1:0]           last_q;
  logic [1:0]           widx_q;

  logic [NUM_REQ-1:0]   win;
  logic [1:0]           win_idx;
  logic [WORD_W-1:0]    sel_data_d;
  logic [SS_W-1:0]      sel_ss_d;

  rr_arb3 u_rr_arb3 (
    .req     (req),
    .last    (last_q),
    .win     (win),
    .win_idx (win_idx)
  );

  always_comb begin
    sel_data_d = req_data[WORD_W-1:0];
    sel_ss_d   = req_ss[SS_W-1:0];
    case (win_idx)
      2'd1: begin
        sel_data_d = req_data[2*WORD_W-1:WORD_W];
        sel_ss_d   = req_ss[2*SS_W-1:SS_W];
      end
      2'd2: begin
        sel_data_d = req_data[3*WORD_W-1:2*WORD_W];
        sel_ss_d   = req_ss[3*SS_W-1:2*SS_W];
      end
      default: ;
    endcase
  end

  assign cnt_d = cnt_q + CNT_W'(1);

  // SPI_done is only looked at in BUSY and wins over a coinciding terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      rsp_q   <= '0;
      terr_q  <= 1'b0;
      wrt_q   <= 1'b0;
      data_q  <= '0;
      ss_q    <= '0;
      cnt_q   <= '0;
      last_q  <= LAST_RESET;
      widx_q  <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= '0;
          terr_q <= 1'b0;
          if (|req) begin
            state_q <= ST_LAUNCH;
            gnt_q   <= win;
            widx_q  <= win_idx;
            data_q  <= sel_data_d;
            ss_q    <= sel_ss_d;
            wrt_q   <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          wrt_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_BUSY;
        end
        ST_BUSY: begin
          if (SPI_done) begin
            rsp_q   <= SPI_rdata;
            done_q  <= gnt_q;
            state_q <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            rsp_q   <= RESP_TIMEOUT;
            terr_q  <= 1'b1;
            done_q  <= gnt_q;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DONE: begin
          done_q  <= '0;
          terr_q  <= 1'b0;
          gnt_q   <= '0;
          last_q  <= widx_q;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rsp_data    = rsp_q;
  assign timeout_err = terr_q;
  assign wrt_SPI     = wrt_q;
  assign SPI_data    = data_q;
  assign ss          = ss_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Randomized self-checking bench for spi_arbiter against a transaction-level
// model of round-robin order, launch timing, completion latency and timeout.
module tb_spi_arbiter;

  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [8:0]  req_ss;
  logic [47:0] req_data;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic [7:0]  rsp_data;
  logic        timeout_err;
  logic        wrt_SPI;
  logic [15:0] SPI_data;
  logic [2:0]  ss;
  logic        SPI_done;
  logic [7:0]  SPI_rdata;

  int checks;
  int errors;
  int model_last;
  logic [7:0] exp_rsp;

  spi_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_ss      (req_ss),
    .req_data    (req_data),
    .gnt         (gnt),
    .done        (done),
    .rsp_data    (rsp_data),
    .timeout_err (timeout_err),
    .wrt_SPI     (wrt_SPI),
    .SPI_data    (SPI_data),
    .ss          (ss),
    .SPI_done    (SPI_done),
    .SPI_rdata   (SPI_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // First requester at or after last+1 (mod 3) that is asserting req
  function automatic int model_pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last + k) % 3;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [47:0] rand_data();
    return 48'({$urandom(), $urandom()});
  endfunction

  // Starts and ends on a falling edge with the DUT in IDLE.
  // lat < 0 means the SPI master never answers.
  task automatic run_txn(input logic [2:0] r, input logic [47:0] d, input logic [8:0] s,
                         input logic [7:0] rd, input int lat, input bit disturb,
                         output logic [2:0] g_obs);
    int          w;
    logic [2:0]  g_exp;
    logic [15:0] d_exp;
    logic [2:0]  s_exp;
    bit          tmo;
    bit          stray;
    w     = model_pick(r, model_last);
    g_exp = 3'(1 << w);
    d_exp = d[w*16 +: 16];
    s_exp = s[w*3 +: 3];
    req      = r;
    req_data = d;
    req_ss   = s;
    stray    = ($urandom_range(0, 1) == 1);
    @(negedge clk);
    g_obs = gnt;
    checks++;
    if ({gnt, wrt_SPI, SPI_data, ss, done, timeout_err, rsp_data} !==
        {g_exp, 1'b1, d_exp, s_exp, 3'b000, 1'b0, exp_rsp}) begin
      errors++;
      $display("[TB] FAIL launch: got %h expected %h",
               {gnt, wrt_SPI, SPI_data, ss, done, timeout_err, rsp_data},
               {g_exp, 1'b1, d_exp, s_exp, 3'b000, 1'b0, exp_rsp});
    end
    if (stray) begin
      SPI_done  = 1'b1;
      SPI_rdata = 8'($urandom());
    end
    @(negedge clk);
    SPI_done = 1'b0;
    if (disturb) begin
      req      = 3'b000;
      req_data = rand_data();
      req_ss   = 9'($urandom());
    end
    tmo = 1'b1;
    for (int c = 0; c < TO; c++) begin
      checks++;
      if ({gnt, wrt_SPI, SPI_data, ss, done, timeout_err, rsp_data} !==
          {g_exp, 1'b0, d_exp, s_exp, 3'b000, 1'b0, exp_rsp}) begin
        errors++;
        $display("[TB] FAIL busy[%0d]: got %h expected %h", c,
                 {gnt, wrt_SPI, SPI_data, ss, done, timeout_err, rsp_data},
                 {g_exp, 1'b0, d_exp, s_exp, 3'b000, 1'b0, exp_rsp});
      end
      if (c == lat) begin
        SPI_done  = 1'b1;
        SPI_rdata = rd;
        tmo       = 1'b0;
        @(negedge clk);
        SPI_done  = 1'b0;
        SPI_rdata = 8'($urandom());
        break;
      end
      @(negedge clk);
    end
    exp_rsp = tmo ? 8'hEE : rd;
    checks++;
    if ({gnt, wrt_SPI, SPI_data, ss, done, timeout_err, rsp_data} !==
        {g_exp, 1'b0, d_exp, s_exp, g_exp, tmo, exp_rsp}) begin
      errors++;
      $display("[TB] FAIL done: got %h expected %h",
               {gnt, wrt_SPI, SPI_data, ss, done, timeout_err, rsp_data},
               {g_exp, 1'b0, d_exp, s_exp, g_exp, tmo, exp_rsp});
    end
    model_last = w;
    @(negedge clk);
    checks++;
    if ({gnt, wrt_SPI, done, timeout_err, rsp_data} !== {3'b000, 1'b0, 3'b000, 1'b0, exp_rsp}) begin
      errors++;
      $display("[TB] FAIL idle_after: got %h expected %h",
               {gnt, wrt_SPI, done, timeout_err, rsp_data},
               {3'b000, 1'b0, 3'b000, 1'b0, exp_rsp});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 3'b000;
    @(negedge clk);
    rst        = 1'b0;
    model_last = 2;
    exp_rsp    = 8'h00;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({gnt, done, wrt_SPI, timeout_err, rsp_data, SPI_data, ss} !== 35'd0) begin
      errors++;
      $display("[TB] FAIL reset_async: got %h expected 0",
               {gnt, done, wrt_SPI, timeout_err, rsp_data, SPI_data, ss});
    end
    @(negedge clk);
    rst        = 1'b0;
    model_last = 2;
    exp_rsp    = 8'h00;
    @(negedge clk);
    checks++;
    if ({gnt, done, wrt_SPI, timeout_err, rsp_data, SPI_data, ss} !== 35'd0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got %h expected 0",
               {gnt, done, wrt_SPI, timeout_err, rsp_data, SPI_data, ss});
    end
  endtask

  task automatic test_single();
    logic [2:0] g;
    run_txn(3'b001, {32'h0, 16'h1328}, {6'b0, 3'b001}, 8'h5A, 2, 1'b0, g);
    checks++;
    if (g !== 3'b001 || rsp_data !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL single: gnt %b rsp %h expected 001 5a", g, rsp_data);
    end
  endtask

  task automatic test_fairness();
    logic [2:0] g;
    logic [2:0] exp_order [4];
    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_txn(3'b111, rand_data(), 9'($urandom()), 8'($urandom()), $urandom_range(0, 5), 1'b0, g);
      checks++;
      if (g !== exp_order[i]) begin
        errors++;
        $display("[TB] FAIL fairness[%0d]: gnt %b expected %b", i, g, exp_order[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [2:0] g;
    run_txn(3'b010, rand_data(), 9'($urandom()), 8'h33, -1, 1'b0, g);
  endtask

  task automatic test_race();
    logic [2:0] g;
    run_txn(3'b001, rand_data(), 9'($urandom()), 8'hC3, TO - 1, 1'b0, g);
  endtask

  task automatic test_drop_change();
    logic [2:0] g;
    run_txn(3'b100, rand_data(), 9'($urandom()), 8'($urandom()), $urandom_range(2, 6), 1'b1, g);
    checks++;
    if (g !== 3'b100) begin
      errors++;
      $display("[TB] FAIL drop_change: gnt %b expected 100", g);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] g;
    req      = 3'b001;
    req_data = rand_data();
    req_ss   = 9'($urandom());
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, done, wrt_SPI, timeout_err, rsp_data, SPI_data, ss} !== 35'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got %h expected 0",
               {gnt, done, wrt_SPI, timeout_err, rsp_data, SPI_data, ss});
    end
    @(negedge clk);
    checks++;
    if ({gnt, done, timeout_err} !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_hold: got %h expected 0", {gnt, done, timeout_err});
    end
    rst        = 1'b0;
    req        = 3'b000;
    model_last = 2;
    exp_rsp    = 8'h00;
    @(negedge clk);
    run_txn(3'b010, rand_data(), 9'($urandom()), 8'($urandom()), 1, 1'b0, g);
    checks++;
    if (g !== 3'b010) begin
      errors++;
      $display("[TB] FAIL reset_mid_next: gnt %b expected 010", g);
    end
  endtask

  task automatic test_random();
    logic [2:0] g;
    for (int n = 0; n < 30; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int i = 0; i < gap; i++) begin
        req       = 3'b000;
        SPI_done  = ($urandom_range(0, 1) == 1);
        SPI_rdata = 8'($urandom());
        @(negedge clk);
        SPI_done = 1'b0;
        checks++;
        if ({gnt, wrt_SPI, done, timeout_err, rsp_data} !== {3'b000, 1'b0, 3'b000, 1'b0, exp_rsp}) begin
          errors++;
          $display("[TB] FAIL idle_gap: got %h expected %h",
                   {gnt, wrt_SPI, done, timeout_err, rsp_data},
                   {3'b000, 1'b0, 3'b000, 1'b0, exp_rsp});
        end
      end
      run_txn(3'($urandom_range(1, 7)), rand_data(), 9'($urandom()), 8'($urandom()),
              $urandom_range(0, TO + 2), ($urandom_range(0, 3) == 0), g);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    model_last = 2;
    exp_rsp    = 8'h00;
    rst        = 1'b1;
    req        = 3'b000;
    req_ss     = '0;
    req_data   = '0;
    SPI_done   = 1'b0;
    SPI_rdata  = 8'h00;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_race();
    test_drop_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: BUSY cycles allowed before abort.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req  input  3  per-requester request; bit0 = command path, bit1 = calibration fetch, bit2 = trigger-level refresh.
REQ-005 req_ss  input  9  slave select per requester, 3 bits each; [2:0] is requester 0.
REQ-006 req_data  input  48  16-bit SPI word per requester; [15:0] is requester 0.
REQ-007 gnt  output  3  one-hot grant to the requester owning the SPI master.
REQ-008 done  output  3  one-cycle completion pulse to the owning requester.
REQ-009 rsp_data  output  8  read byte from the last transaction, or 8'hEE on timeout.
REQ-010 timeout_err  output  1  one-cycle pulse when a transaction aborts.
REQ-011 wrt_SPI  output  1  one-cycle launch strobe to the SPI master.
REQ-012 SPI_data  output  16  word to transmit; valid whenever gnt is nonzero.
REQ-013 ss  output  3  slave select; valid whenever gnt is nonzero.
REQ-014 SPI_done  input  1  SPI master completion pulse.
REQ-015 SPI_rdata  input  8  byte returned by the SPI master; valid with SPI_done.

Function
REQ-016 The FSM SHALL have four states, IDLE, LAUNCH, BUSY and DONE, with transitions IDLE->LAUNCH->BUSY->DONE->IDLE.
REQ-017 In IDLE with req nonzero:
- the winner SHALL be chosen by round-robin priority order (last+1, last+2, last) mod 3, where last is the previous winner;
- the winner's req_ss and req_data SHALL be latched;
- the FSM SHALL move to LAUNCH.
REQ-018 In IDLE with req all-zero, the FSM SHALL remain in IDLE with gnt=0.
REQ-019 gnt SHALL be asserted from LAUNCH through DONE inclusive, and SHALL be zero in IDLE.
REQ-020 wrt_SPI SHALL be high for exactly the single LAUNCH cycle, one cycle after req is first sampled high in IDLE.
REQ-021 SPI_data and ss SHALL come from the latched registers and SHALL stay stable from LAUNCH through DONE.
REQ-022 In BUSY, a 12-bit-minimum counter SHALL increment each cycle, starting at 0 on entry.
REQ-023 SPI_done in BUSY SHALL register SPI_rdata into rsp_data and move the FSM to DONE.
REQ-024 When the counter reaches TIMEOUT_CYCLES-1 without SPI_done:
- rsp_data SHALL become 8'hEE;
- timeout_err SHALL pulse in the DONE cycle;
- the FSM SHALL move to DONE.
REQ-025 If SPI_done coincides with the terminal count, SPI_done SHALL win: data is captured and no error is raised.
REQ-026 SPI_done seen outside BUSY SHALL be ignored.
REQ-027 In DONE, done[winner] SHALL pulse for one cycle, last SHALL update to the winner, and the FSM SHALL return to IDLE.
REQ-028 rsp_data SHALL hold its value until the next DONE.
REQ-029 A requester dropping req mid-transaction SHALL NOT abort it; done still pulses.
REQ-030 Changes to req_ss or req_data after latching SHALL have no effect on the transaction in flight.
REQ-031 A requester re-asserting req in the cycle after done SHALL be arbitrated normally; there is a minimum of one IDLE cycle between transactions.

Reset
REQ-032 On rst, the block SHALL take the following values immediately, independent of clk:
- state=IDLE;
- gnt=0, done=0, wrt_SPI=0, timeout_err=0;
- rsp_data=8'h00, SPI_data=16'h0000, ss=3'b000;
- counter=0;
- last=2, so requester 0 has highest priority first.
REQ-033 Reset mid-transaction SHALL abort the transaction without a done pulse; the SPI master is reset by the same rst.

Structure
REQ-034 The shared package SHALL hold:
- the state enum;
- NUM_REQ=3;
- RESP_TIMEOUT=8'hEE;
- the TIMEOUT_CYCLES default.
REQ-035 Round-robin selection SHALL be a combinational sub-module rr_arb3 (inputs req[2:0] and last[1:0]; outputs one-hot win[2:0] and win_idx[1:0]).

Verification
REQ-036 Single request: req=3'b001, req_data[15:0]=16'h1328, req_ss[2:0]=3'b001 -> wrt_SPI pulses one cycle later with SPI_data=16'h1328 and ss=3'b001; SPI_done with SPI_rdata=8'h5A -> done=3'b001 and rsp_data=8'h5A.
REQ-037 Fairness: req=3'b111 held for three transactions after reset -> grant order 0, 1, 2, and the fourth transaction grants 0.
REQ-038 Timeout: TIMEOUT_CYCLES=16, SPI_done never asserted -> done and timeout_err pulse 16 cycles after BUSY entry, rsp_data=8'hEE.
REQ-039 Race: SPI_done coincides with the terminal count -> no timeout_err, rsp_data=SPI_rdata.
REQ-040 Reset mid-transaction: rst asserted in BUSY -> all outputs zero immediately, no done pulse; next req=3'b010 is granted to requester 1.
REQ-041 Requester 2 drops req and changes req_data during BUSY -> SPI_data unchanged, done=3'b100 still pulses.
